// File: rtl/exec_sequencer.sv
// -----------------------------------------------------------------------------
// exec_sequencer
//
// Execution sequencer for a small teaching processor. Three debounced push
// buttons are turned into single-cycle events. These events, together with
// a free-running prescaler in RUN mode, produce the load strobes for the
// instruction selector and the PC advance enable. A HALT instruction freezes
// the sequencer until reset.
//
// Parameters
//   RUN_DIV    clk cycles between automatic fetches in RUN (2 .. 2^26)
//
// Ports
//   clk        system clock, all state on the rising edge
//   reset      asynchronous, active-high reset
//   btn_fpga   level button: execute the instruction on the board switches
//   btn_step   level button: execute the next instruction-memory word
//   btn_run    level button: toggle continuous run
//   halt_inst  decoder flag: the currently selected instruction is HALT
//   pulse4     one-cycle strobe: selector loads the switch instruction
//   pulse5     one-cycle strobe: selector loads the instruction-memory word
//   halt       high exactly while the sequencer is HALTED
//   pc_en      one-cycle PC advance enable, the cycle after pulse5
//   state      IDLE=00, RUN=01, HALTED=10
// -----------------------------------------------------------------------------
module exec_sequencer #(
    parameter int unsigned RUN_DIV = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_fpga,
    input  logic       btn_step,
    input  logic       btn_run,
    input  logic       halt_inst,
    output logic       pulse4,
    output logic       pulse5,
    output logic       halt,
    output logic       pc_en,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        HALTED = 2'b10
    } state_t;

    localparam logic [25:0] TERM_COUNT = 26'(RUN_DIV - 1);

    state_t      cur_state;

    // Synchronizer chains: bit 0 is s1, bit 1 is s2, bit 2 is s3.
    logic [2:0]  fpga_sync;
    logic [2:0]  step_sync;
    logic [2:0]  run_sync;

    // Registered single-cycle events (rising edge seen between s2 and s3).
    logic        fpga_event;
    logic        step_event;
    logic        run_event;

    logic [25:0] prescaler;
    logic        at_term;

    // Registered copy of pulse5; becomes pc_en unless the loaded word is HALT.
    logic        pc_flag;

    assign at_term = (prescaler == TERM_COUNT);

    // -------------------------------------------------------------------------
    // Button synchronizers and edge detectors.
    // Chains reset to all ones so a button held through reset release looks
    // like a steady high level and never yields an event. The event register
    // is cleared so nothing detected before reset can survive it.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fpga_sync  <= 3'b111;
            step_sync  <= 3'b111;
            run_sync   <= 3'b111;
            fpga_event <= 1'b0;
            step_event <= 1'b0;
            run_event  <= 1'b0;
        end else begin
            fpga_sync  <= {fpga_sync[1:0], btn_fpga};
            step_sync  <= {step_sync[1:0], btn_step};
            run_sync   <= {run_sync[1:0], btn_run};
            fpga_event <= fpga_sync[1] & ~fpga_sync[2];
            step_event <= step_sync[1] & ~step_sync[2];
            run_event  <= run_sync[1] & ~run_sync[2];
        end
    end

    // -------------------------------------------------------------------------
    // Sequencer FSM with registered strobes.
    // halt_inst is checked before any event so that the edge which sees HALT
    // never issues a strobe.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state <= IDLE;
            pulse4    <= 1'b0;
            pulse5    <= 1'b0;
            prescaler <= 26'd0;
            pc_flag   <= 1'b0;
        end else begin
            pulse4  <= 1'b0;
            pulse5  <= 1'b0;
            pc_flag <= pulse5;
            case (cur_state)
                IDLE: begin
                    if (halt_inst) begin
                        cur_state <= HALTED;
                    end else if (fpga_event) begin
                        pulse4 <= 1'b1;
                    end else if (step_event) begin
                        pulse5 <= 1'b1;
                    end else if (run_event) begin
                        cur_state <= RUN;
                        prescaler <= 26'd0;
                    end
                end
                RUN: begin
                    if (halt_inst) begin
                        cur_state <= HALTED;
                    end else begin
                        // Leaving RUN freezes the prescaler; otherwise it wraps
                        // even when an fpga strobe steals the terminal count.
                        if (run_event) begin
                            cur_state <= IDLE;
                        end else if (at_term) begin
                            prescaler <= 26'd0;
                        end else begin
                            prescaler <= prescaler + 26'd1;
                        end
                        if (fpga_event) begin
                            pulse4 <= 1'b1;
                        end else if (at_term && !run_event) begin
                            pulse5 <= 1'b1;
                        end
                    end
                end
                HALTED: begin
                    // Only reset leaves HALTED.
                end
                default: begin
                    cur_state <= IDLE;
                end
            endcase
        end
    end

    assign halt  = (cur_state == HALTED);
    assign state = cur_state;
    assign pc_en = pc_flag & ~halt_inst;

endmodule
